// File: rtl/mac_acc_block.sv
// mac_acc_block: accumulates masked product beats into a wide sum per dot
// product and presents the result on a valid/ready port.
// Optional build macro MAC_ACC_SAT_EN: the accumulator clamps to all-ones on
// overflow instead of wrapping.
module mac_acc_block #(
   parameter int unsigned IN_WIDTH       = 40,
   parameter int unsigned GUARD          = 8,
   parameter int unsigned CNT_WIDTH      = 8,
   parameter int unsigned MAC_MIN_WIDTH  = 8,
   parameter int unsigned MAC_CONF_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic [MAC_CONF_WIDTH-1:0] cfg,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [IN_WIDTH+GUARD-1:0] out_data,
   output logic [CNT_WIDTH-1:0]      out_count,
   output logic                      out_ovf
);

   localparam int unsigned ACC_WIDTH = IN_WIDTH + GUARD;
   localparam int unsigned LEN_W     = $clog2(IN_WIDTH + 1);

   // Precision mode codes
   localparam logic [1:0] MAC_SINGLE = 2'd0;
   localparam logic [1:0] MAC_DUAL   = 2'd1;
   localparam logic [1:0] MAC_QUAD   = 2'd2;

   // Quad mode needs the full 5*MIN-bit beat to fit in the input port
   generate
      if (IN_WIDTH < 5 * MAC_MIN_WIDTH) begin : g_width_chk
         $error("mac_acc_block: IN_WIDTH must be >= 5*MAC_MIN_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic [1:0]            r_cfg;
   logic                  r_ovf;

   state_t                w_state_nxt;
   logic [ACC_WIDTH-1:0]  w_acc_nxt;
   logic [CNT_WIDTH-1:0]  w_cnt_nxt;
   logic [1:0]            w_cfg_nxt;
   logic                  w_ovf_nxt;

   logic [1:0]            w_mode;
   logic [LEN_W-1:0]      w_len;
   logic [IN_WIDTH-1:0]   w_masked;
   logic [ACC_WIDTH:0]    w_sum;
   logic                  w_carry;
   logic [ACC_WIDTH-1:0]  w_acc_add;
   logic [CNT_WIDTH-1:0]  w_cnt_inc;

   // Outputs are straight decodes/copies of registered state
   assign in_ready  = (r_state != ST_DONE);
   assign out_valid = (r_state == ST_DONE);
   assign out_data  = r_acc;
   assign out_count = r_cnt;
   assign out_ovf   = r_ovf;

   // First beat of a dot product uses live cfg; later beats use the latched mode
   assign w_mode = (r_state == ST_IDLE) ? cfg[1:0] : r_cfg;

   // Mask the beat to the mode width; unknown modes contribute zero
   always_comb begin
      w_len = '0;
      case (w_mode)
         MAC_SINGLE: w_len = LEN_W'(2 * MAC_MIN_WIDTH);
         MAC_DUAL:   w_len = LEN_W'(3 * MAC_MIN_WIDTH);
         MAC_QUAD:   w_len = LEN_W'(5 * MAC_MIN_WIDTH);
         default:    w_len = '0;
      endcase
      w_masked = in_data & ~({IN_WIDTH{1'b1}} << w_len);
   end

   assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_masked);
   assign w_carry   = w_sum[ACC_WIDTH];
   assign w_cnt_inc = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + CNT_WIDTH'(1);

`ifdef MAC_ACC_SAT_EN
   assign w_acc_add = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
   assign w_acc_add = w_sum[ACC_WIDTH-1:0];
`endif

   // Next-state and datapath update; clr overrides everything else
   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_cfg_nxt   = r_cfg;
      w_ovf_nxt   = r_ovf;
      if (clr) begin
         w_state_nxt = ST_IDLE;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
         w_ovf_nxt   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  w_acc_nxt   = ACC_WIDTH'(w_masked);
                  w_cnt_nxt   = CNT_WIDTH'(1);
                  w_cfg_nxt   = cfg[1:0];
                  w_ovf_nxt   = 1'b0;
                  w_state_nxt = in_last ? ST_DONE : ST_ACC;
               end
            end
            ST_ACC: begin
               if (in_valid) begin
                  w_acc_nxt = w_acc_add;
                  w_cnt_nxt = w_cnt_inc;
                  w_ovf_nxt = r_ovf | w_carry;
                  if (in_last) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  w_state_nxt = ST_IDLE;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_ovf_nxt   = 1'b0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_cfg   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cfg   <= w_cfg_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_mac_acc_block.sv
// Bench for mac_acc_block: directed cases plus randomized dot products checked
// against an arithmetic reference (true sum, then wrap or clamp at 2^40).
module tb_mac_acc_block;

   localparam int unsigned IN_W  = 40;
   localparam int unsigned GUARD = 0;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned ACC_W = IN_W + GUARD;
   localparam longint unsigned LIMIT = 64'h100_0000_0000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             clr = 1'b0;
   logic [1:0]       cfg = 2'd0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int n_checks = 0;
   int n_errors = 0;

   longint unsigned q_dat[$];
   logic [1:0]      q_cfg[$];

   mac_acc_block #(
      .IN_WIDTH(IN_W), .GUARD(GUARD), .CNT_WIDTH(CNT_W),
      .MAC_MIN_WIDTH(8), .MAC_CONF_WIDTH(2)
   ) u_dut (
      .clk(clk), .rst(rst), .clr(clr), .cfg(cfg),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference masking: SINGLE=16, DUAL=24, QUAD=40 bits, other modes zero
   function automatic longint unsigned mask_beat(input logic [1:0] c, input longint unsigned d);
      case (c)
         2'd0:    return d & 64'hFFFF;
         2'd1:    return d & 64'hFF_FFFF;
         2'd2:    return d & 64'hFF_FFFF_FFFF;
         default: return 64'd0;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive the queued beats as one dot product, check the result, hold it
   // under backpressure, then optionally release it.
   task automatic do_dp(input int gap_max, input int hold, input bit release_it);
      longint unsigned sum;
      longint unsigned exp_d;
      bit              ovf;
      int              n;
      int              exp_c;
      logic [1:0]      c0;
      sum = 0;
      n   = q_dat.size();
      c0  = q_cfg[0];
      foreach (q_dat[i]) sum += mask_beat(c0, q_dat[i]);
      ovf = (sum >= LIMIT);
`ifdef MAC_ACC_SAT_EN
      exp_d = ovf ? LIMIT - 1 : sum;
`else
      exp_d = sum % LIMIT;
`endif
      exp_c = (n > 15) ? 15 : n;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap_max)) cycle();
         check("in_ready_acc", 64'(in_ready), 64'd1);
         cfg      = q_cfg[i];
         in_data  = IN_W'(q_dat[i]);
         in_last  = (i == n - 1);
         in_valid = 1'b1;
         cycle();
         in_valid = 1'b0;
         in_last  = 1'b0;
         cfg      = 2'($urandom);
      end
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_data", 64'(out_data), exp_d);
      check("out_count", 64'(out_count), 64'(exp_c));
      check("out_ovf", 64'(out_ovf), 64'(ovf));
      check("in_ready_done", 64'(in_ready), 64'd0);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1'b1;
         in_last  = 1'b1;
         in_data  = IN_W'({32'($urandom), 32'($urandom)});
         cycle();
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_data", 64'(out_data), exp_d);
         check("hold_count", 64'(out_count), 64'(exp_c));
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      if (release_it) begin
         out_ready = 1'b1;
         cycle();
         out_ready = 1'b0;
         in_valid  = 1'b0;
         in_last   = 1'b0;
         check("rel_valid", 64'(out_valid), 64'd0);
         check("rel_in_ready", 64'(in_ready), 64'd1);
         check("rel_data", 64'(out_data), 64'd0);
         check("rel_count", 64'(out_count), 64'd0);
         check("rel_ovf", 64'(out_ovf), 64'd0);
      end
      q_dat.delete();
      q_cfg.delete();
   endtask

   task automatic push(input logic [1:0] c, input longint unsigned d);
      q_cfg.push_back(c);
      q_dat.push_back(d);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_count", 64'(out_count), 64'd0);
      check("rst_ovf", 64'(out_ovf), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      cycle();

      // SINGLE 3+5+7
      push(2'd0, 64'h3); push(2'd0, 64'h5); push(2'd0, 64'h7);
      do_dp(0, 0, 1);
      // QUAD and DUAL masking of a full-width beat
      push(2'd2, 64'hFFFF_FFFF_FFFF);
      do_dp(0, 0, 1);
      push(2'd1, 64'hFF_FFFF_FFFF);
      do_dp(0, 0, 1);
      // Unsupported mode contributes zero
      push(2'd3, 64'h1234);
      do_dp(0, 0, 1);
      // Backpressure for 5 cycles with a beat offered
      push(2'd0, 64'h11); push(2'd0, 64'h22);
      do_dp(1, 5, 1);
      // Overflow at 2^40
      push(2'd2, 64'hFF_FFFF_FFFF); push(2'd2, 64'h2);
      do_dp(0, 0, 1);
      // Count saturation, with mode changes mid-stream ignored
      for (int i = 0; i < 20; i++) push((i == 0) ? 2'd0 : 2'($urandom), 64'h1_0001);
      do_dp(0, 0, 1);

      // clr in ACC after two beats drops the in-flight sum and the same-cycle beat
      cfg = 2'd0; in_data = IN_W'(4); in_valid = 1'b1;
      cycle();
      in_data = IN_W'(6);
      cycle();
      clr = 1'b1; in_data = IN_W'(5); in_last = 1'b1;
      cycle();
      clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("clr_valid", 64'(out_valid), 64'd0);
      check("clr_data", 64'(out_data), 64'd0);
      check("clr_count", 64'(out_count), 64'd0);
      check("clr_in_ready", 64'(in_ready), 64'd1);
      push(2'd0, 64'h9);
      do_dp(0, 0, 1);

      // Asynchronous reset while a result is held
      push(2'd2, 64'hABCD); push(2'd2, 64'h1234);
      do_dp(0, 2, 0);
      #2;
      rst = 1'b0;
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_data", 64'(out_data), 64'd0);
      check("arst_count", 64'(out_count), 64'd0);
      check("arst_ovf", 64'(out_ovf), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      cycle();
      push(2'd1, 64'h77);
      do_dp(0, 0, 1);

      // Randomized dot products
      for (int t = 0; t < 40; t++) begin
         int n;
         n = ($urandom_range(0, 7) == 0) ? 18 : $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            longint unsigned d;
            d = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 2) == 0) d &= 64'hFF;
            push(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), d);
         end
         do_dp(2, $urandom_range(0, 3), 1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
